// File: rtl/top.sv
// Cartridge-bus command sniffer: synchronizes ntr_clk/ntr_data, frames 8-byte commands
// and latches led when a frame equals MATCH_CMD. Optional idle timeout via NTR_TIMEOUT_EN.
module top #(
    parameter logic [63:0] MATCH_CMD      = 64'hFF00_0000_0000_01FF,
    parameter int          TIMEOUT_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] ntr_data,
    input  logic       ntr_clk,
    output logic       led
);

    logic [2:0]  sync_reg;
    logic [2:0]  valid_reg;
    logic [7:0]  data_s1_reg;
    logic [7:0]  data_s2_reg;
    logic [63:0] shift_reg;
    logic [2:0]  byte_cnt_reg;
    logic        led_reg;

    logic        strobe;
    logic        timed_out;
    logic [2:0]  byte_cnt_eff;
    logic [63:0] shift_next;
    logic        frame_done;

    // valid_reg tracks which sync stages hold real samples since reset, so an ntr_clk
    // already high at reset release is seen as a level, not as a rising edge.
    assign strobe       = valid_reg[2] & sync_reg[1] & ~sync_reg[2];
    assign byte_cnt_eff = timed_out ? 3'd0 : byte_cnt_reg;
    assign shift_next   = {shift_reg[55:0], data_s2_reg};
    assign frame_done   = strobe && (byte_cnt_eff == 3'd7);
    assign led          = led_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_reg    <= '0;
            valid_reg   <= '0;
            data_s1_reg <= '0;
            data_s2_reg <= '0;
        end else begin
            sync_reg    <= {sync_reg[1:0], ntr_clk};
            valid_reg   <= {valid_reg[1:0], 1'b1};
            data_s1_reg <= ntr_data;
            data_s2_reg <= data_s1_reg;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shift_reg    <= '0;
            byte_cnt_reg <= '0;
            led_reg      <= 1'b0;
        end else if (strobe) begin
            shift_reg    <= shift_next;
            byte_cnt_reg <= byte_cnt_eff + 3'd1;
            if (frame_done && (shift_next == MATCH_CMD)) begin
                led_reg <= 1'b1;
            end
        end else if (timed_out) begin
            byte_cnt_reg <= '0;
        end
    end

`ifdef NTR_TIMEOUT_EN
    localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [IDLE_W-1:0] idle_reg;

    assign timed_out = (idle_reg == IDLE_W'(TIMEOUT_CYCLES));

    // Saturates at TIMEOUT_CYCLES; a strobe in the saturated cycle starts a new frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            idle_reg <= '0;
        end else if (strobe) begin
            idle_reg <= '0;
        end else if (!timed_out) begin
            idle_reg <= idle_reg + IDLE_W'(1);
        end
    end
`else
    assign timed_out = 1'b0;
`endif

endmodule

// File: tb/tb_top.sv
// Self-checking bench for top: a byte-level reference model pushes the expected led
// value per byte into a queue, popped and compared 4 clk cycles after each ntr_clk rise.
module tb_top;

    localparam logic [63:0] MATCH   = 64'hFF00_0000_0000_01FF;
    localparam logic [63:0] BAD     = 64'hFF00_0000_0000_01FE;
    localparam int          TIMEOUT = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ntr_clk = 1'b0;
    logic [7:0] ntr_data = 8'h00;
    logic       led;

    int n_checks = 0;
    int n_fail   = 0;

    bit          exp_q[$];
    logic [63:0] m_sr  = '0;
    int          m_cnt = 0;
    bit          m_led = 1'b0;

    always #5 clk = ~clk;

    top #(
        .MATCH_CMD(MATCH),
        .TIMEOUT_CYCLES(TIMEOUT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .ntr_data(ntr_data),
        .ntr_clk(ntr_clk),
        .led(led)
    );

    task automatic model_byte(input logic [7:0] b);
        m_sr = {m_sr[55:0], b};
        if (m_cnt == 7) begin
            m_cnt = 0;
            if (m_sr == MATCH) m_led = 1'b1;
        end else begin
            m_cnt++;
        end
    endtask

    task automatic model_reset();
        m_sr  = '0;
        m_cnt = 0;
        m_led = 1'b0;
        exp_q.delete();
    endtask

    task automatic do_reset(input int cycles, input bit toggle);
        rst = 1'b1;
        for (int i = 0; i < cycles; i++) begin
            if (toggle) ntr_clk = ~ntr_clk;
            @(posedge clk); #1;
        end
        rst = 1'b0;
        model_reset();
    endtask

    task automatic settle();
        ntr_clk = 1'b0;
        repeat (5) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input string tag);
        bit exp;
        ntr_data = b;
        @(posedge clk); #1;
        ntr_clk = 1'b1;
        model_byte(b);
        exp_q.push_back(m_led);
        repeat (4) @(posedge clk);
        #1;
        exp = exp_q.pop_front();
        n_checks++;
        if (led !== exp) begin
            n_fail++;
            $display("FAIL %s byte %02h: led=%0b expected %0b", tag, b, led, exp);
        end else begin
            $display("ok   %s byte %02h: led=%0b", tag, b, led);
        end
        @(posedge clk); #1;
        ntr_clk = 1'b0;
        repeat (5) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [63:0] f, input string tag);
        for (int i = 0; i < 8; i++) send_byte(f[63-8*i -: 8], tag);
    endtask

    task automatic check_led(input bit exp, input string tag);
        n_checks++;
        if (led !== exp) begin
            n_fail++;
            $display("FAIL %s: led=%0b expected %0b", tag, led, exp);
        end else begin
            $display("ok   %s: led=%0b", tag, led);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
`ifdef NTR_TIMEOUT_EN
        if (n >= TIMEOUT) m_cnt = 0;
`endif
    endtask

    task automatic test_reset();
        do_reset(2, 1'b1);
        settle();
        check_led(1'b0, "reset_led");
        // ntr_clk held high across reset release must not count as a byte
        ntr_clk = 1'b1;
        do_reset(2, 1'b0);
        repeat (6) @(posedge clk);
        #1;
        ntr_clk = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        send_frame(MATCH, "reset_high_release");
        check_led(1'b1, "reset_high_release_led");
    endtask

    task automatic test_match();
        do_reset(2, 1'b0);
        settle();
        send_frame(MATCH, "match");
        check_led(1'b1, "match_led");
        for (int i = 0; i < 6; i++) send_byte(8'h00, "match_hold");
        check_led(1'b1, "match_latched");
    endtask

    task automatic test_mismatch();
        do_reset(2, 1'b0);
        settle();
        send_frame(BAD, "mismatch");
        check_led(1'b0, "mismatch_led");
        send_frame(MATCH, "mismatch_then_match");
        check_led(1'b1, "mismatch_then_match_led");
    endtask

    task automatic test_midframe_reset();
        do_reset(2, 1'b0);
        settle();
        for (int i = 0; i < 3; i++) send_byte(MATCH[63-8*i -: 8], "mid_partial");
        do_reset(1, 1'b0);
        settle();
        send_frame(MATCH, "mid_after_rst");
        check_led(1'b1, "mid_after_rst_led");
        do_reset(2, 1'b0);
        settle();
        for (int i = 0; i < 3; i++) send_byte(MATCH[63-8*i -: 8], "mis_partial");
        send_frame(MATCH, "misaligned");
        check_led(1'b0, "misaligned_led");
    endtask

    task automatic test_timeout();
        bit exp;
`ifdef NTR_TIMEOUT_EN
        exp = 1'b1;
`else
        exp = 1'b0;
`endif
        do_reset(2, 1'b0);
        settle();
        for (int i = 0; i < 3; i++) send_byte(MATCH[63-8*i -: 8], "to_partial");
        idle(20);
        send_frame(MATCH, "to_frame");
        check_led(exp, "timeout_led");
    endtask

    task automatic test_glitch();
        logic [7:0] b;
        do_reset(2, 1'b0);
        settle();
        for (int i = 0; i < 24; i++) begin
            b = (i % 2 == 0) ? 8'h00 : 8'h5A;
            ntr_data = b;
            @(posedge clk); #1;
            ntr_clk = 1'b1;
            repeat ((i % 3 == 0) ? 1 : 5) @(posedge clk);
            #1;
            ntr_clk = 1'b0;
            repeat (5) @(posedge clk);
            #1;
        end
        check_led(1'b0, "glitch_led");
    endtask

    initial begin
        test_reset();
        test_match();
        test_mismatch();
        test_midframe_reset();
        test_timeout();
        test_glitch();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/top.md
TOP -- requirements
Module: top

Interface
REQ-001 Parameter MATCH_CMD, default 64'hFF00_0000_0000_01FF; the 8-byte command that lights the LED; byte 0 (first received) in bits [63:56].
REQ-002 Parameter TIMEOUT_CYCLES, default 16; the number of clk cycles without an ntr_clk rising edge that ends a partial frame; used only when NTR_TIMEOUT_EN is defined.
REQ-003 Port clk, input, 1 bit; the single system clock; all state updates on its rising edge.
REQ-004 Port rst, input, 1 bit; synchronous reset, active-high.
REQ-005 Port ntr_data, input, 8 bits; the cartridge bus data byte, asynchronous to clk.
REQ-006 Port ntr_clk, input, 1 bit; the cartridge bus strobe, asynchronous to clk; data is valid at its rising edge.
REQ-007 Port led, output, 1 bit; the command-match indicator, registered.

Function
REQ-008 ntr_clk SHALL pass through a 2-flop synchronizer in the clk domain, plus a third flop for edge detection.
REQ-009 A rising edge (synchronized value 1, previous value 0) SHALL produce a one-cycle strobe; falling edges are ignored.
REQ-010 ntr_data SHALL go through a 2-stage register pipeline aligned with ntr_clk; the byte sampled on the strobe cycle is the byte present at the ntr_clk rising edge.
REQ-011 Input constraint: ntr_clk high time and low time are each at least 2 clk cycles; ntr_data is stable from 1 clk cycle before the ntr_clk rise until 2 clk cycles after it.
REQ-012 On each strobe, the captured byte SHALL shift into a 64-bit shift register (new byte in bits [7:0]).
REQ-013 On each strobe, a 3-bit byte counter SHALL increment.
REQ-014 When the strobe arrives with the counter at 7 (8th byte), the counter SHALL wrap to 0 and the frame is complete.
REQ-015 On frame completion, the full 64-bit value including the 8th byte SHALL be compared to MATCH_CMD.
REQ-016 If the values are equal, led SHALL go to 1 on the next clk edge and stay latched until reset.
REQ-017 A non-matching frame SHALL NOT clear led.
REQ-018 A partial frame (fewer than 8 bytes) SHALL never affect led.
REQ-019 There is no handshake and no back-pressure; every strobe is accepted.
REQ-020 The compare completes in the strobe cycle, so led latency is 1 clk cycle after the 8th strobe; total latency from the 8th ntr_clk rise is at most 4 clk cycles.
REQ-021 The shift register SHALL keep shifting across frames; the comparison is framed only by the byte counter.
REQ-022 If rst and a strobe occur in the same cycle, rst wins and the byte is discarded.

Reset
REQ-023 When rst=1 at a clk edge, the following SHALL be cleared:
- led = 0
- byte counter = 0
- shift register = 0
- synchronizer and edge flops = 0
- data pipeline = 0
- timeout counter = 0
REQ-024 Reset asserted mid-frame SHALL discard the partial frame; the next strobe after reset is byte 0.
REQ-025 An ntr_clk already high when reset is released SHALL NOT produce a strobe until it falls and rises again.

Configuration
REQ-026 Macro NTR_TIMEOUT_EN.
REQ-027 With NTR_TIMEOUT_EN defined:
- an idle counter increments every clk cycle without a strobe and clears on a strobe;
- when it reaches TIMEOUT_CYCLES, the byte counter resets to 0 and the idle counter saturates;
- the shift register and led are unaffected.
REQ-028 Without NTR_TIMEOUT_EN, no idle counter SHALL exist and frames are delimited only by the byte count.

Verification
REQ-029 Reset: rst=1 for 2 cycles with ntr_clk toggling -> led=0 and byte counter=0 afterwards.
REQ-030 Match: bytes FF,00,00,00,00,00,01,FF, 5 clk high / 5 clk low each -> led=1 within 4 clk cycles of the 8th rise; led still 1 after 6 further bytes of 00.
REQ-031 Mismatch: bytes FF,00,00,00,00,00,01,FE -> led stays 0; then a correct 8-byte frame -> led=1.
REQ-032 Mid-frame reset: 3 bytes, then rst pulse, then the full matching frame -> led=1; the 3 bytes without reset plus the same frame -> led=0, because the frame is misaligned.
REQ-033 NTR_TIMEOUT_EN defined, TIMEOUT_CYCLES=16: 3 bytes, 20 idle clk cycles, then the matching frame -> led=1; without the macro, the same stimulus -> led=0.
REQ-034 Glitch: an ntr_clk high pulse of 1 clk cycle is outside the input constraint; the bench checks only that led does not go to 1 for a non-matching stream.
